// File: rtl/morse_seq_game_pkg.sv
// Shared definitions for the morse-sequence memory game: state codes and
// default symbol/buffer dimensions used by the top level and the rate divider.
package morse_seq_game_pkg;

   localparam int SYM_W_DEF = 3;
   localparam int DEPTH_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_P1_ENTER = 2'd1,
      S_P2_ENTER = 2'd2,
      S_RESULT   = 2'd3
   } state_t;

endpackage

// File: rtl/morse_seq_game_sym_capture.sv
// Thermometer-coded symbol capture: each tick with the key held shifts in a one,
// saturating at all-ones. Clear has priority, so a commit drops a same-cycle tick.
module sym_capture #(
   parameter int SYM_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             tick,
   input  logic             key_in,
   input  logic             clear,
   output logic [SYM_W-1:0] sym
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         sym <= '0;
      end else if (clear) begin
         sym <= '0;
      end else if (en && tick && key_in) begin
         sym <= {sym[SYM_W-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/morse_seq_game.sv
// Two-player morse-sequence memory game: player 1 stores a symbol sequence,
// player 2 replays it and is scored against the stored buffer.
module morse_seq_game
   import morse_seq_game_pkg::*;
#(
   parameter int  SYM_W  = SYM_W_DEF,
   parameter int  DEPTH  = DEPTH_DEF,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int CNT_W  = ADDR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             tick,
   input  logic             key_in,
   input  logic             next_in,
   input  logic             done_in,
   input  logic             strict,
   output logic [1:0]       state,
   output logic [SYM_W-1:0] cur_sym,
   output logic [CNT_W-1:0] p1_len,
   output logic [CNT_W-1:0] p2_idx,
   output logic [CNT_W-1:0] score,
   output logic             full,
   output logic             complete,
   output logic             correct
);

   state_t           state_q, state_d;
   logic [SYM_W-1:0] mem [DEPTH];
   logic [CNT_W-1:0] p1_len_q, p2_idx_q, score_q;
   logic [CNT_W-1:0] p1_len_post, p2_idx_inc;
   logic             p1_commit, p2_cmp, sym_match, round_start;
   logic             cap_en, cap_clear;

   assign p1_commit   = (state_q == S_P1_ENTER) && next_in && (cur_sym != '0) && !full;
   assign p2_cmp      = (state_q == S_P2_ENTER) && next_in;
   assign sym_match   = (cur_sym == mem[p2_idx_q[ADDR_W-1:0]]);
   assign round_start = (state_q == S_IDLE) && done_in;
   assign p1_len_post = p1_commit ? p1_len_q + 1'b1 : p1_len_q;
   assign p2_idx_inc  = p2_idx_q + 1'b1;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (done_in) state_d = S_P1_ENTER;
         end
         S_P1_ENTER: begin
            if (done_in && (p1_len_post != '0)) state_d = S_P2_ENTER;
         end
         S_P2_ENTER: begin
            if (done_in) begin
               state_d = S_RESULT;
            end else if (p2_cmp && ((p2_idx_inc == p1_len_q) || (!sym_match && strict))) begin
               state_d = S_RESULT;
            end
         end
         S_RESULT: begin
            if (done_in) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         p1_len_q <= '0;
         p2_idx_q <= '0;
         score_q  <= '0;
      end else if (round_start) begin
         p1_len_q <= '0;
         p2_idx_q <= '0;
         score_q  <= '0;
      end else begin
         p1_len_q <= p1_len_post;
         if (p2_cmp) begin
            p2_idx_q <= p2_idx_inc;
            if (sym_match) score_q <= score_q + 1'b1;
         end
      end
   end

   // NOTE: the symbol buffer is deliberately not reset; only the write enable is gated by reset.
   always_ff @(posedge clock) begin
      if (!reset && p1_commit) mem[p1_len_q[ADDR_W-1:0]] <= cur_sym;
   end

   assign cap_en    = (state_q == S_P1_ENTER) || (state_q == S_P2_ENTER);
   assign cap_clear = (state_d != state_q) || p1_commit || p2_cmp;

   sym_capture #(.SYM_W(SYM_W)) u_sym_capture (
      .clock  (clock),
      .reset  (reset),
      .en     (cap_en),
      .tick   (tick),
      .key_in (key_in),
      .clear  (cap_clear),
      .sym    (cur_sym)
   );

   assign state    = state_q;
   assign p1_len   = p1_len_q;
   assign p2_idx   = p2_idx_q;
   assign score    = score_q;
   assign full     = (p1_len_q == CNT_W'(DEPTH));
   assign complete = (state_q == S_RESULT);
   assign correct  = complete && (score_q == p1_len_q);

endmodule
